// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store unit driving a word-wide data memory with RMW sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module lsu_mem_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_misalign,
  output logic              rsp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, LD_WAIT, RMW_RD, RMW_WR} state_t;
  state_t state_q, state_d;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q, ea;
  logic [15:0]       wdata_q;
  logic [31:0]       merged_q, merged_d, rsp_rdata_q, rsp_rdata_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_mis_q, rsp_mis_d, rsp_flt_q, rsp_flt_d;
  logic              accept, size_h, size_w, legal, fault, mis_flag, trap, rd_c, wr_c;
  logic [ADDR_W:0]   top;
  logic [4:0]        sh;
  logic [31:0]       lane_sh, ld_ext, merge;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  assign req_ready = reset && state_q == IDLE;
  assign accept    = req_valid && req_ready;
  assign size_h    = req_funct3[1:0] == 2'b01;
  assign size_w    = req_funct3[1:0] == 2'b10;
  // 011/111 never legal; 1xx only legal as LBU/LHU loads
  assign legal = req_funct3[1:0] != 2'b11 && !(req_funct3[2] && (req_we || req_funct3[1]));
  assign top   = {1'b0, req_addr[ADDR_W-1:2], 2'b00} + (ADDR_W+1)'(3);
  assign fault = !legal || top >= (ADDR_W+1)'(MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
  assign ea       = req_addr;
  assign mis_flag = (size_h && req_addr[0]) || (size_w && req_addr[1:0] != 2'b00);
`else
  assign ea       = size_h ? {req_addr[ADDR_W-1:1], 1'b0} :
                    size_w ? {req_addr[ADDR_W-1:2], 2'b00} : req_addr;
  assign mis_flag = 1'b0;
`endif
  assign trap    = fault || mis_flag;
  assign sh      = {addr_q[1:0], 3'b000};
  assign lane_sh = mem_rdata >> sh;
  assign ld_b    = lane_sh[7:0];
  assign ld_h    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ld_ext  = f3_q[1:0] == 2'b00 ? {{24{ld_b[7] & ~f3_q[2]}}, ld_b} :
                   f3_q[1:0] == 2'b01 ? {{16{ld_h[15] & ~f3_q[2]}}, ld_h} : mem_rdata;
  assign merge   = f3_q[0] ? (addr_q[1] ? {wdata_q, mem_rdata[15:0]} : {mem_rdata[31:16], wdata_q}) :
                   (mem_rdata & ~(32'hFF << sh)) | ({24'b0, wdata_q[7:0]} << sh);
  assign mem_read  = rd_c && reset;
  assign mem_write = wr_c && reset;
  assign mem_addr  = state_q == IDLE ? {ea[ADDR_W-1:2], 2'b00} : {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = state_q == RMW_WR ? merged_q : req_wdata;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_misalign = rsp_mis_q;
  assign rsp_fault    = rsp_flt_q;
  always_comb begin
    state_d     = state_q;
    merged_d    = merged_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_mis_d   = rsp_mis_q;
    rsp_flt_d   = rsp_flt_q;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (trap) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_mis_d   = mis_flag;
          rsp_flt_d   = fault;
        end else if (!req_we) begin
          rd_c    = 1'b1;
          state_d = LD_WAIT;
        end else if (size_w) begin
          wr_c        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_mis_d   = 1'b0;
          rsp_flt_d   = 1'b0;
        end else begin
          rd_c    = 1'b1;
          state_d = RMW_RD;
        end
      end
      LD_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_ext;
        rsp_mis_d   = 1'b0;
        rsp_flt_d   = 1'b0;
        state_d     = IDLE;
      end
      RMW_RD: begin
        merged_d = merge;
        state_d  = RMW_WR;
      end
      RMW_WR: begin
        wr_c        = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_mis_d   = 1'b0;
        rsp_flt_d   = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      merged_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_mis_q   <= 1'b0;
      rsp_flt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      merged_q    <= merged_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_flt_q   <= rsp_flt_d;
      if (accept) begin
        f3_q    <= req_funct3;
        addr_q  <= ea;
        wdata_q <= req_wdata[15:0];
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: random and directed load/store traffic checked against a byte-array reference model.
module tb_lsu_mem_ctrl;
  localparam int MEMB = 128;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_we = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata, mem_addr, mem_wdata, mem_rdata = '0;
  logic req_ready, rsp_valid, rsp_misalign, rsp_fault, mem_read, mem_write;
  logic [31:0] env_mem [MEMB/4];
  logic [7:0]  ref_mem [MEMB];
  logic [31:0] last_rd, last_wd;
  int n_chk = 0, n_fail = 0, bad = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign), .rsp_fault(rsp_fault), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always @(posedge clk) begin
    if (mem_write) env_mem[mem_addr[6:2]] <= mem_wdata;
    if (mem_read) mem_rdata <= env_mem[mem_addr[6:2]];
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) bad++;
    if (!reset && (mem_read || mem_write || req_ready)) bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int sz, nbytes, val, lat, nr, nw, wcyc, e_lat, e_nr, e_nw, e_wcyc, w;
    logic legal, flt, mis, trapped, e_mis;
    logic [31:0] ea, wa, e_rd, e_wd, g_wd, g_ma, g_rd;
    logic g_mis, g_flt;
    sz = int'(f3[1:0]);
    nbytes = 1 << sz;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    flt = !legal || ((addr & ~32'd3) + 32'd3 >= MEMB);
    mis = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
    e_mis = TRAP && mis;
    trapped = flt || e_mis;
    ea = (TRAP || sz == 0 || sz == 3) ? addr : addr - (addr % nbytes);
    wa = ea & ~32'd3;
    e_rd = 0; e_wd = 0; e_nr = 0; e_nw = 0; e_wcyc = 0;
    if (trapped) e_lat = 1;
    else if (!we) begin
      e_lat = 2; e_nr = 1;
      val = 0;
      for (int i = 0; i < nbytes; i++) val += int'(ref_mem[ea+i]) << (8 * i);
      if (!f3[2] && nbytes < 4 && val >= (1 << (8 * nbytes - 1))) val -= 1 << (8 * nbytes);
      e_rd = 32'(val);
    end else begin
      for (int i = 0; i < nbytes; i++) ref_mem[ea+i] = wd[8*i +: 8];
      e_wd = ref_word(int'(wa));
      e_nw = 1;
      e_lat = (nbytes == 4) ? 1 : 3;
      e_nr = (nbytes == 4) ? 0 : 1;
      e_wcyc = (nbytes == 4) ? 0 : 2;
    end
    w = 0;
    while (!req_ready && w < 5) begin @(negedge clk); w++; end
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    nr = 0; nw = 0; wcyc = -1; g_wd = 0; g_ma = 0; lat = 0;
    g_rd = 32'hX; g_mis = 1'bX; g_flt = 1'bX;
    for (int k = 0; k <= 6; k++) begin
      if (k == 0) #1;
      else if (rsp_valid) begin
        lat = k; g_rd = rsp_rdata; g_mis = rsp_misalign; g_flt = rsp_fault;
        break;
      end
      if (mem_read) begin nr++; g_ma = mem_addr; end
      if (mem_write) begin nw++; wcyc = k; g_wd = mem_wdata; g_ma = mem_addr; end
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
    end
    check("latency", 32'(lat), 32'(e_lat));
    check("rdata", g_rd, e_rd);
    check("misalign", 32'(g_mis), 32'(e_mis));
    check("fault", 32'(g_flt), 32'(flt));
    check("mem_reads", 32'(nr), 32'(e_nr));
    check("mem_writes", 32'(nw), 32'(e_nw));
    if (e_nw != 0) begin
      check("write_cycle", 32'(wcyc), 32'(e_wcyc));
      check("mem_wdata", g_wd, e_wd);
    end
    if (e_nr + e_nw != 0) check("mem_addr", g_ma, wa);
    last_rd = g_rd; last_wd = g_wd;
  endtask

  initial begin
    for (int i = 0; i < MEMB / 4; i++) begin
      env_mem[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = env_mem[i][8*b +: 8];
    end
    repeat (3) @(negedge clk);
    check("rst_rsp", {rsp_valid, rsp_misalign, rsp_fault}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);
    do_req(1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_req(0, 3'd2, 32'h10, 0);
    check("plan_lw", last_rd, 32'hDEADBEEF);
    do_req(1, 3'd0, 32'h11, 32'h000000A5);
    check("plan_sb_merge", last_wd, 32'hDEADA5EF);
    do_req(0, 3'd0, 32'h11, 0);
    check("plan_lb", last_rd, 32'hFFFFFFA5);
    do_req(0, 3'd4, 32'h11, 0);
    check("plan_lbu", last_rd, 32'h000000A5);
    do_req(1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_req(1, 3'd1, 32'h12, 32'h00001234);
    check("plan_sh_merge", last_wd, 32'h1234BEEF);
    do_req(0, 3'd1, 32'h12, 0);
    check("plan_lh", last_rd, 32'h00001234);
    do_req(0, 3'd5, 32'h10, 0);
    check("plan_lhu", last_rd, 32'h0000BEEF);
    do_req(0, 3'd1, 32'h10, 0);
    check("plan_lh_neg", last_rd, 32'hFFFFBEEF);
    do_req(0, 3'd2, 32'h13, 0);
    do_req(0, 3'd3, 32'h10, 0);
    do_req(0, 3'd2, 32'h7C, 0);
    do_req(0, 3'd2, 32'h80, 0);
    // reset lands one cycle into an SB read-modify-write
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'h5A;
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_rsp", {rsp_valid, rsp_misalign, rsp_fault}, 32'd0);
      check("midrst_rdata", rsp_rdata, 32'd0);
      check("midrst_ready", 32'(req_ready), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready_rel", 32'(req_ready), 32'd1);
    check("midrst_no_write", 32'(mem_write), 32'd0);
    do_req(0, 3'd2, 32'h20, 0);
    for (int n = 0; n < 200; n++)
      do_req(1'($urandom), 3'($urandom), 32'($urandom_range(0, 32'h87)), $urandom);
    for (int i = 0; i < MEMB; i += 4) do_req(0, 3'd2, 32'(i), 0);
    check("protocol", 32'(bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
